// File: rtl/scp_operator.sv
// Operator-side command driver for the SCP-079 containment FSM: escalates
// green->yellow->red on alarms, cools down, locks out, and watches the timer for stalls.
module scp_operator #(
  parameter int unsigned YELLOW_CYCLES = 8,
  parameter int unsigned CLEAR_CYCLES  = 4,
  parameter int unsigned COOL_CYCLES   = 6,
  parameter int unsigned MAX_ESC       = 3,
  parameter int unsigned STALL_CYCLES  = 40
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       a1,
  input  logic       a2,
  input  logic       a3,
  input  logic       cheat_out,
  input  logic [5:0] timer,
  output logic       green,
  output logic       yellow,
  output logic       red,
  output logic [2:0] phase,
  output logic [3:0] esc_count,
  output logic       locked,
  output logic       stall
);

  typedef enum logic [2:0] {
    PH_GREEN  = 3'd0,
    PH_YELLOW = 3'd1,
    PH_RED    = 3'd2,
    PH_COOL   = 3'd3,
    PH_LOCK   = 3'd4
  } phase_e;

  localparam logic [7:0] YEL_LOAD  = 8'(YELLOW_CYCLES - 1);
  localparam logic [7:0] CLR_LOAD  = 8'(CLEAR_CYCLES - 1);
  localparam logic [7:0] COOL_LOAD = 8'(COOL_CYCLES - 1);
  localparam logic [3:0] ESC_LIMIT = 4'(MAX_ESC);
  localparam logic [7:0] STALL_MAX = 8'(STALL_CYCLES);

  phase_e     phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] esc_q, esc_d;
  logic [3:0] esc_inc;
  logic       escalate;
  logic       alarm;
  logic [7:0] scnt_q, scnt_d;
  logic [5:0] snap_q, snap_d;
  logic       stall_q, stall_d;

  assign alarm   = a1 | a2 | a3;
  assign esc_inc = (esc_q == 4'hF) ? 4'hF : esc_q + 4'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q <= PH_GREEN;
      cnt_q   <= 8'd0;
      esc_q   <= 4'd0;
      scnt_q  <= 8'd0;
      snap_q  <= 6'd0;
      stall_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      esc_q   <= esc_d;
      scnt_q  <= scnt_d;
      snap_q  <= snap_d;
      stall_q <= stall_d;
    end
  end

  // Phase FSM: cheat_out outranks alarm, which outranks counter expiry.
  always_comb begin
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    esc_d    = esc_q;
    escalate = 1'b0;
    case (phase_q)
      PH_GREEN: begin
        if (cheat_out) escalate = 1'b1;
        else if (alarm) begin
          phase_d = PH_YELLOW;
          cnt_d   = YEL_LOAD;
        end
      end
      PH_YELLOW: begin
        if (cheat_out)         escalate = 1'b1;
        else if (!alarm)       phase_d  = PH_GREEN;
        else if (cnt_q == 8'd0) escalate = 1'b1;
        else                   cnt_d    = cnt_q - 8'd1;
      end
      PH_RED: begin
        if (alarm || cheat_out) cnt_d = CLR_LOAD;
        else if (cnt_q == 8'd0) begin
          phase_d = PH_COOL;
          cnt_d   = COOL_LOAD;
        end else cnt_d = cnt_q - 8'd1;
      end
      PH_COOL: begin
        if (alarm || cheat_out) escalate = 1'b1;
        else if (cnt_q == 8'd0) phase_d  = PH_GREEN;
        else                    cnt_d    = cnt_q - 8'd1;
      end
      PH_LOCK: ;
      default: phase_d = PH_GREEN;
    endcase
    if (escalate) begin
      esc_d = esc_inc;
      if (esc_inc >= ESC_LIMIT) phase_d = PH_LOCK;
      else begin
        phase_d = PH_RED;
        cnt_d   = CLR_LOAD;
      end
    end
  end

  // Stall watchdog is frozen in LOCK; the counter parks at STALL_MAX.
  always_comb begin
    scnt_d  = scnt_q;
    snap_d  = snap_q;
    stall_d = stall_q;
    if (phase_q != PH_LOCK) begin
      if (timer != snap_q) begin
        snap_d = timer;
        scnt_d = 8'd0;
      end else if (scnt_q != STALL_MAX) begin
        scnt_d = scnt_q + 8'd1;
        if (scnt_q + 8'd1 == STALL_MAX) stall_d = 1'b1;
      end
    end
  end

  assign phase     = phase_q;
  assign green     = (phase_q == PH_GREEN);
  assign yellow    = (phase_q == PH_YELLOW) || (phase_q == PH_COOL);
  assign red       = (phase_q == PH_RED) || (phase_q == PH_LOCK);
  assign locked    = (phase_q == PH_LOCK);
  assign esc_count = esc_q;
  assign stall     = stall_q;

endmodule

// File: tb/tb_scp_operator.sv
// Bench for scp_operator: a cycle model pushes expected outputs per edge,
// popped and compared after each edge, plus directed duration checks.
module tb_scp_operator;

  logic       clock, reset;
  logic       a1, a2, a3, cheat_out;
  logic [5:0] timer;
  logic       green, yellow, red, locked, stall;
  logic [2:0] phase;
  logic [3:0] esc_count;

  scp_operator dut (
    .clock(clock), .reset(reset), .a1(a1), .a2(a2), .a3(a3),
    .cheat_out(cheat_out), .timer(timer), .green(green), .yellow(yellow),
    .red(red), .phase(phase), .esc_count(esc_count), .locked(locked),
    .stall(stall)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];
  logic        tmr_run;

  // reference model state
  int m_phase, m_cnt, m_esc, m_scnt, m_snap;
  bit m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_vec();
    logic g, y, r, l;
    g = (m_phase == 0);
    y = (m_phase == 1) || (m_phase == 3);
    r = (m_phase == 2) || (m_phase == 4);
    l = (m_phase == 4);
    return {3'(m_phase), 4'(m_esc), l, m_stall, g, y, r};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {phase, esc_count, locked, stall, green, yellow, red};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_esc = 0; m_scnt = 0; m_snap = 0; m_stall = 0;
  endtask

  task automatic escalate_m();
    m_esc = (m_esc == 15) ? 15 : m_esc + 1;
    if (m_esc >= 3) m_phase = 4;
    else begin m_phase = 2; m_cnt = 3; end
  endtask

  task automatic model_next();
    bit al;
    int ph;
    al = a1 | a2 | a3;
    ph = m_phase;
    if (ph != 4) begin
      if (timer != 6'(m_snap)) begin m_snap = timer; m_scnt = 0; end
      else if (m_scnt != 40) begin
        m_scnt++;
        if (m_scnt == 40) m_stall = 1;
      end
    end
    case (ph)
      0: if (cheat_out) escalate_m(); else if (al) begin m_phase = 1; m_cnt = 7; end
      1: if (cheat_out) escalate_m(); else if (!al) m_phase = 0;
         else if (m_cnt == 0) escalate_m(); else m_cnt--;
      2: if (al || cheat_out) m_cnt = 3;
         else if (m_cnt == 0) begin m_phase = 3; m_cnt = 5; end else m_cnt--;
      3: if (al || cheat_out) escalate_m(); else if (m_cnt == 0) m_phase = 0; else m_cnt--;
      default: ;
    endcase
  endtask

  // driver: inputs are already set; advance one edge and score it
  task automatic step(input string tag);
    if (tmr_run) timer = timer + 6'd1;
    model_next();
    exp_q.push_back(model_vec());
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) chk({tag, "_empty"}, 32'd1, 32'd0);
    else chk(tag, 32'(dut_vec()), 32'(exp_q.pop_front()));
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    chk({tag, "_async"}, 32'(dut_vec()), 32'(model_vec()));
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b0; a1 = 0; a2 = 0; a3 = 0; cheat_out = 0;
    timer = 6'd5; tmr_run = 1'b1;
    model_reset();
    @(posedge clock); #1;
    do_reset("por");

    // quiet run, timer moving
    for (int i = 0; i < 100; i++) step("quiet");
    chk("quiet_green", 32'(green), 32'd1);

    // short alarm pulse
    a2 = 1; n = 0;
    for (int i = 0; i < 3; i++) begin step("a2_pulse"); if (yellow) n++; end
    a2 = 0; step("a2_release");
    chk("a2_yellow_len", n, 3);
    chk("a2_back_green", 32'(phase), 32'd0);

    // held alarm: yellow length, red hold, cool length
    a1 = 1; n = 0;
    for (int i = 0; i < 40 && !red; i++) begin step("a1_hold"); if (yellow) n++; end
    chk("a1_yellow_len", n, 8);
    chk("a1_esc", 32'(esc_count), 32'd1);
    a1 = 0; n = 0;
    for (int i = 0; i < 40 && red; i++) begin step("red_clear"); n++; end
    chk("red_clear_len", n, 4);
    n = yellow ? 1 : 0;
    for (int i = 0; i < 40 && !green; i++) begin step("cool"); if (yellow) n++; end
    chk("cool_len", n, 6);

    // escalation to lock
    do_reset("pre_lock");
    cheat_out = 1; step("cheat1"); cheat_out = 0;
    chk("cheat1_red", 32'(red), 32'd1);
    chk("cheat1_esc", 32'(esc_count), 32'd1);
    for (int i = 0; i < 4; i++) step("clear1");
    cheat_out = 1; step("cheat2"); cheat_out = 0;
    for (int i = 0; i < 4; i++) step("clear2");
    a3 = 1; step("esc3"); a3 = 0;
    chk("lock_phase", 32'(phase), 32'd4);
    chk("lock_locked", 32'(locked), 32'd1);
    for (int i = 0; i < 20; i++) begin
      a1 = 1'($urandom_range(0, 1)); a2 = 1'($urandom_range(0, 1));
      cheat_out = 1'($urandom_range(0, 1));
      step("lock_hold");
    end
    a1 = 0; a2 = 0; cheat_out = 0;
    chk("lock_esc_frozen", 32'(esc_count), 32'd3);
    do_reset("lock_exit");

    // stall watchdog
    step("pre_stall");
    tmr_run = 1'b0; timer = 6'd17; n = 0;
    for (int i = 0; i < 80 && !stall; i++) begin step("stall_wait"); n++; end
    chk("stall_unchanged_cycles", n - 1, 40);
    tmr_run = 1'b1;
    for (int i = 0; i < 10; i++) step("stall_sticky");
    chk("stall_sticky", 32'(stall), 32'd1);
    do_reset("stall_clear");

    // reset between edges in YELLOW
    a1 = 1; step("y_enter"); step("y_hold");
    chk("in_yellow", 32'(yellow), 32'd1);
    #2;
    do_reset("mid_yellow");
    a1 = 0;

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      a1 = ($urandom_range(0, 9) < 3);
      a2 = ($urandom_range(0, 19) == 0);
      a3 = ($urandom_range(0, 19) == 0);
      cheat_out = ($urandom_range(0, 49) == 0);
      tmr_run = ($urandom_range(0, 3) != 0);
      step("random");
      if (m_phase == 4 && $urandom_range(0, 3) == 0) do_reset("random_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
